// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch queue and the issue buffer it feeds:
// default widths, the lane-count type and the count-clamping helper.
package dispatch_pkg;

    localparam int DEF_DATA_WIDTH = 47;
    localparam int DEF_W          = 4;

    // Lane count 0..W needs one bit more than $clog2(W).
    typedef logic [$clog2(DEF_W):0] lane_ct_t;

    // Smaller of two counts; used for every handshake clamp.
    function automatic int min_ct(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/dispatch_queue_lane_mux.sv
// Read rotator: presents W consecutive entries of the storage array starting
// at rd_ptr, wrapping modulo DEPTH. Lane 0 is the oldest entry.
module dispatch_queue_lane_mux #(
    parameter int DATA_WIDTH = 47,
    parameter int W          = 4,
    parameter int DEPTH      = 16
) (
    input  logic [DATA_WIDTH-1:0]        mem [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [DATA_WIDTH*W-1:0]      out_data
);

    localparam int AW = $clog2(DEPTH);

    // Each lane reads its own slot; the address add wraps naturally at AW bits.
    for (genvar gi = 0; gi < W; gi++) begin : g_lane
        logic [AW-1:0] addr;
        assign addr = rd_ptr + AW'(gi);
        assign out_data[DATA_WIDTH*gi +: DATA_WIDTH] = mem[addr];
    end

endmodule

// File: rtl/dispatch_queue.sv
// Multi-lane in-order FIFO between rename and the issue buffer.
// Up to W entries in and W entries out per cycle using count handshakes.
// Both ready/valid counts come from registered state only, so there is no
// combinational path from the issue side back to rename.
// Optional build macro DISPATCH_QUEUE_PERF_EN adds stall/empty counters.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int W          = DEF_W,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_WIDTH*W-1:0]  in_data,
    input  logic [$clog2(W):0]       in_valid_ct,
    output logic [$clog2(W):0]       in_ready_ct,
    output logic [DATA_WIDTH*W-1:0]  out_data,
    output logic [$clog2(W):0]       out_valid_ct,
    input  logic [$clog2(W):0]       out_ready_ct
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_full_stall,
    output logic [31:0]              perf_empty_cycles
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CTW = $clog2(W) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg,  count_next;

    int in_ready_int;
    int out_valid_int;
    int in_valid_int;
    int push_int;
    int pop_int;

    // Lane-split view of the incoming bundle.
    logic [DATA_WIDTH-1:0] in_lane [W];
    for (genvar gi = 0; gi < W; gi++) begin : g_in_lane
        assign in_lane[gi] = in_data[DATA_WIDTH*gi +: DATA_WIDTH];
    end

    // Handshake counts and next-state pointers; illegal counts clamp to W.
    always_comb begin
        in_ready_int  = min_ct(W, DEPTH - int'(count_reg));
        out_valid_int = min_ct(W, int'(count_reg));
        in_valid_int  = min_ct(int'(in_valid_ct), W);
        push_int      = min_ct(in_valid_int, in_ready_int);
        pop_int       = min_ct(min_ct(int'(out_ready_ct), W), out_valid_int);

        wr_ptr_next   = wr_ptr_reg + AW'(push_int);
        rd_ptr_next   = rd_ptr_reg + AW'(pop_int);
        count_next    = count_reg + CW'(push_int) - CW'(pop_int);
    end

    assign in_ready_ct  = CTW'(in_ready_int);
    assign out_valid_ct = CTW'(out_valid_int);

    // Pointer and occupancy state; reset beats flush beats normal traffic.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write: accepted lanes land at consecutive slots from wr_ptr.
    // Storage itself is never cleared; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < W; i++) begin
                if (i < push_int) begin
                    mem[wr_ptr_reg + AW'(i)] <= in_lane[i];
                end
            end
        end
    end

    dispatch_queue_lane_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .W          (W),
        .DEPTH      (DEPTH)
    ) u_lane_mux (
        .mem      (mem),
        .rd_ptr   (rd_ptr_reg),
        .out_data (out_data)
    );

    // Producer and consumer must never offer more than W lanes.
    a_in_valid_legal: assert property (@(posedge clk) disable iff (rst)
        in_valid_ct <= CTW'(W));
    a_out_ready_legal: assert property (@(posedge clk) disable iff (rst)
        out_ready_ct <= CTW'(W));

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] perf_full_stall_reg;
    logic [31:0] perf_empty_cycles_reg;

    // Saturating performance counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_stall_reg   <= '0;
            perf_empty_cycles_reg <= '0;
        end else begin
            if (in_valid_int > in_ready_int && perf_full_stall_reg != '1) begin
                perf_full_stall_reg <= perf_full_stall_reg + 32'd1;
            end
            if (count_reg == '0 && perf_empty_cycles_reg != '1) begin
                perf_empty_cycles_reg <= perf_empty_cycles_reg + 32'd1;
            end
        end
    end

    assign perf_full_stall   = perf_full_stall_reg;
    assign perf_empty_cycles = perf_empty_cycles_reg;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue (W=4, DEPTH=16). A queue-based
// reference model tracks contents; the producer re-presents any lanes that
// were not accepted, so ordering checks cover partial accepts and wrap.
module tb_dispatch_queue;

    localparam int DW    = 47;
    localparam int W     = 4;
    localparam int DEPTH = 16;
    localparam int NSTIM = 256;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [DW*W-1:0]   in_data;
    logic [2:0]        in_valid_ct;
    logic [2:0]        in_ready_ct;
    logic [DW*W-1:0]   out_data;
    logic [2:0]        out_valid_ct;
    logic [2:0]        out_ready_ct;
`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0]       perf_full_stall;
    logic [31:0]       perf_empty_cycles;
`endif

    dispatch_queue #(
        .DATA_WIDTH (DW),
        .W          (W),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid_ct  (in_valid_ct),
        .in_ready_ct  (in_ready_ct),
        .out_data     (out_data),
        .out_valid_ct (out_valid_ct),
        .out_ready_ct (out_ready_ct)
`ifdef DISPATCH_QUEUE_PERF_EN
        ,
        .perf_full_stall   (perf_full_stall),
        .perf_empty_cycles (perf_empty_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [DW-1:0] stim [NSTIM];
    logic [DW-1:0] model_q [$];
    int            seq;
    longint        exp_stall;
    longint        exp_empty;

    int n_checks;
    int n_fail;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the model.
    task automatic check_state(input string tag);
        int sz;
        int ov;
        sz = model_q.size();
        ov = imin(W, sz);
        check_val({tag, ".out_valid_ct"}, 64'(out_valid_ct), 64'(ov));
        check_val({tag, ".in_ready_ct"}, 64'(in_ready_ct), 64'(imin(W, DEPTH - sz)));
        for (int k = 0; k < ov; k++) begin
            check_val($sformatf("%s.lane%0d", tag, k), 64'(out_data[DW*k +: DW]), 64'(model_q[k]));
        end
`ifdef DISPATCH_QUEUE_PERF_EN
        check_val({tag, ".perf_full_stall"}, 64'(perf_full_stall), 64'(exp_stall));
        check_val({tag, ".perf_empty_cycles"}, 64'(perf_empty_cycles), 64'(exp_empty));
`endif
    endtask

    task automatic present(input int nv, input int nr);
        for (int k = 0; k < W; k++) begin
            in_data[DW*k +: DW] = stim[(seq + k) % NSTIM];
        end
        in_valid_ct  = 3'(nv);
        out_ready_ct = 3'(nr);
    endtask

    // One clock of traffic: producer offers nv lanes, consumer takes up to nr.
    task automatic cycle(input string tag, input int nv, input int nr, input bit fl);
        int sz;
        int rdy;
        int push;
        int pop;
        sz   = model_q.size();
        rdy  = imin(W, DEPTH - sz);
        push = imin(nv, rdy);
        pop  = imin(nr, imin(W, sz));
        present(nv, nr);
        flush = fl;
        if (nv > rdy) exp_stall++;
        if (sz == 0) exp_empty++;
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
        end else begin
            repeat (pop) void'(model_q.pop_front());
            for (int k = 0; k < push; k++) model_q.push_back(stim[(seq + k) % NSTIM]);
            seq += push;
        end
        flush        = 1'b0;
        in_valid_ct  = '0;
        out_ready_ct = '0;
        check_state(tag);
    endtask

    // Reset held for one cycle while traffic is offered; everything is discarded.
    task automatic do_reset(input string tag, input int nv, input int nr);
        present(nv, nr);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        in_valid_ct  = '0;
        out_ready_ct = '0;
        model_q.delete();
        exp_stall = 0;
        exp_empty = 0;
        check_state(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seq      = 0;
        exp_stall = 0;
        exp_empty = 0;
        rst   = 1'b1;
        flush = 1'b0;
        in_data      = '0;
        in_valid_ct  = '0;
        out_ready_ct = '0;
        for (int i = 0; i < NSTIM; i++) stim[i] = DW'({$urandom, $urandom});

        @(posedge clk);
        #1;
        do_reset("reset", 0, 0);

        // Push three, visible next cycle
        cycle("push3", 3, 0, 1'b0);

        // Fill to full, then an extra push must be refused
        do_reset("reset2", 0, 0);
        for (int i = 0; i < 4; i++) cycle("fill", 4, 0, 1'b0);
        cycle("full_push", 4, 0, 1'b0);

        // Drain to 12 then run steady 2-in/2-out across the pointer wrap
        cycle("drain", 0, 2, 1'b0);
        cycle("drain", 0, 2, 1'b0);
        for (int i = 0; i < 20; i++) cycle("wrap", 2, 2, 1'b0);

        // Partial accept at count 14
        cycle("to14", 2, 0, 1'b0);
        cycle("partial", 4, 0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("drain2", 0, 4, 1'b0);

        // Flush while pushing and popping
        cycle("pre_flush", 4, 0, 1'b0);
        cycle("pre_flush", 4, 0, 1'b0);
        cycle("flush", 4, 2, 1'b1);
        cycle("post_flush", 3, 0, 1'b0);

        // Reset mid-burst
        cycle("pre_rst", 4, 1, 1'b0);
        do_reset("rst_mid", 4, 2);
        cycle("post_rst", 2, 0, 1'b0);

`ifdef DISPATCH_QUEUE_PERF_EN
        do_reset("perf_rst", 0, 0);
        for (int i = 0; i < 4; i++) cycle("perf_fill", 4, 0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("perf_stall", 4, 0, 1'b0);
        check_val("perf_stall_3", 64'(perf_full_stall), 64'd3);
        cycle("perf_flush", 0, 0, 1'b1);
        check_val("perf_stall_after_flush", 64'(perf_full_stall), 64'd3);
        do_reset("perf_rst2", 0, 0);
        check_val("perf_stall_after_rst", 64'(perf_full_stall), 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int nv;
            int nr;
            bit fl;
            nv = int'($urandom_range(0, W));
            nr = int'($urandom_range(0, W));
            fl = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rand_rst", nv, nr);
            end else begin
                cycle("rand", nv, nr, fl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
